cover_collector: RTL and testbench

COVER_COLLECTOR -- requirements
Module: cover_collector

---
 rtl/cover_pkg.sv | 23 ++
 rtl/cover_if.sv | 30 +++
 rtl/cover_popcount.sv | 24 ++
 rtl/cover_collector.sv | 141 ++++++++++++++
 tb/tb_cover_collector.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cover_pkg.sv
// Shared types and default geometry for the coverage collector.
package cover_pkg;

  function automatic int unsigned num_words(int unsigned n, int unsigned w);
    return (n + w - 1) / w;
  endfunction

  localparam int unsigned NumCover = 337;
  localparam int unsigned WordW    = 32;
  localparam int unsigned NumWords = num_words(NumCover, WordW);
  localparam int unsigned CntW     = 9;
  localparam int unsigned IdxW     = 4;

  typedef logic [WordW-1:0] word_t;
  typedef logic [IdxW-1:0]  widx_t;
  typedef logic [CntW-1:0]  cnt_t;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } state_e;

endpackage

// File: rtl/cover_if.sv
// Readout bus: request/index from the reader, grant/valid/data from the collector.
interface cover_if
  import cover_pkg::*;
#(
  parameter int unsigned WordW = cover_pkg::WordW
) ();

  logic             rd_req;
  widx_t            rd_idx;
  logic             rd_gnt;
  logic             rd_valid;
  logic [WordW-1:0] rd_data;

  modport master (
    output rd_req,
    output rd_idx,
    input  rd_gnt,
    input  rd_valid,
    input  rd_data
  );

  modport slave (
    input  rd_req,
    input  rd_idx,
    output rd_gnt,
    output rd_valid,
    output rd_data
  );

endinterface

// File: rtl/cover_popcount.sv
// Purely combinational population count.
module cover_popcount
  import cover_pkg::*;
#(
  parameter int unsigned Width = cover_pkg::NumCover,
  parameter int unsigned CntW  = cover_pkg::CntW
) (
  input  logic [Width-1:0] bits_i,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] shift;

  // Shift-and-add keeps every select constant.
  always_comb begin
    count_o = '0;
    shift   = bits_i;
    for (int unsigned i = 0; i < Width; i++) begin
      count_o = count_o + CntW'(shift[0]);
      shift   = shift >> 1;
    end
  end

endmodule

// File: rtl/cover_collector.sv
// Sticky coverage bitmap with a two-stage new-hit counter, word readout and a
// word-per-cycle clear sequence.
module cover_collector
  import cover_pkg::*;
#(
  parameter int unsigned NumCover = cover_pkg::NumCover,
  parameter int unsigned WordW    = cover_pkg::WordW
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumCover-1:0] cover_i,
  input  logic                en_i,
  input  logic                clear_i,
  cover_if.slave              rd_if,
  output logic                new_cov_o,
  output logic [CntW-1:0]     cov_count_o,
  output logic                busy_o
);

  localparam int unsigned Words = num_words(NumCover, WordW);
  localparam int unsigned PadW  = Words * WordW;

  // Bitmap held as words; bits above NumCover are never set.
  typedef logic [Words-1:0][WordW-1:0] bitmap_t;

  state_e           state_q, state_d;
  widx_t            clr_idx_q, clr_idx_d;
  bitmap_t          seen_q, seen_d;
  logic [PadW-1:0]  cover_pad;
  logic [PadW-1:0]  new_q, new_d;
  cnt_t             cnt_q, cnt_d, new_pop;
  logic             new_cov_q, new_cov_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WordW-1:0] rd_data_q, rd_data_d;
  logic             idle, merge, enter_clr;

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // FSM next state: CLEAR walks word indices 0..Words-1 then returns to IDLE.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      StIdle: begin
        clr_idx_d = '0;
        if (clear_i) state_d = StClear;
      end
      StClear: begin
        if (clr_idx_q == widx_t'(Words - 1)) begin
          state_d   = StIdle;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + widx_t'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs and decoded control strobes; clear beats a same-cycle sample.
  always_comb begin
    idle         = (state_q == StIdle);
    busy_o       = (state_q == StClear);
    rd_if.rd_gnt = rd_if.rd_req & idle;
    merge        = idle & en_i & ~clear_i;
    enter_clr    = idle & clear_i;
  end

  // Pad the cover vector up to a whole number of words.
  always_comb begin
    cover_pad                 = '0;
    cover_pad[NumCover-1:0]   = cover_i;
  end

  cover_popcount #(
    .Width (PadW),
    .CntW  (CntW)
  ) u_popcount (
    .bits_i  (new_q),
    .count_o (new_pop)
  );

  // Stage 1 merge/new-hit detect and stage 2 count; entering or running CLEAR
  // cancels both stages.
  always_comb begin
    seen_d    = seen_q;
    new_d     = '0;
    cnt_d     = cnt_q + new_pop;
    new_cov_d = |new_q;
    if (merge) begin
      seen_d = seen_q | cover_pad;
      new_d  = cover_pad & ~seen_q;
    end
    if (busy_o) seen_d[clr_idx_q] = '0;
    if (enter_clr || busy_o) begin
      cnt_d     = '0;
      new_cov_d = 1'b0;
    end
  end

  // Readout captures the pre-merge word; out-of-range indices read zero.
  always_comb begin
    rd_valid_d = rd_if.rd_gnt;
    rd_data_d  = '0;
    if (rd_if.rd_gnt && (32'(rd_if.rd_idx) < Words)) rd_data_d = seen_q[rd_if.rd_idx];
  end

  // Datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      seen_q     <= '0;
      new_q      <= '0;
      cnt_q      <= '0;
      new_cov_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      seen_q     <= seen_d;
      new_q      <= new_d;
      cnt_q      <= cnt_d;
      new_cov_q  <= new_cov_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign new_cov_o      = new_cov_q;
  assign cov_count_o    = cnt_q;
  assign rd_if.rd_valid = rd_valid_q;
  assign rd_if.rd_data  = rd_data_q;

endmodule

// File: tb/tb_cover_collector.sv
// Self-checking bench: read expectations queued at grant, checked on rd_valid.
module tb_cover_collector;
  import cover_pkg::*;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [NumCover-1:0] cover_i;
  logic                en_i;
  logic                clear_i;
  logic                new_cov_o;
  logic [CntW-1:0]     cov_count_o;
  logic                busy_o;

  cover_if #(.WordW(WordW)) rd_if ();

  cover_collector #(
    .NumCover (NumCover),
    .WordW    (WordW)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cover_i     (cover_i),
    .en_i        (en_i),
    .clear_i     (clear_i),
    .rd_if       (rd_if),
    .new_cov_o   (new_cov_o),
    .cov_count_o (cov_count_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned pulse_cnt = 0;
  word_t       exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard pop on every valid word; data must be zero otherwise.
  always @(negedge clk_i) begin : monitor
    word_t e;
    if (rd_if.rd_valid) begin
      check("rd_outstanding", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rd_data", 64'(rd_if.rd_data), 64'(e));
      end
    end else begin
      check("rd_data_idle", 64'(rd_if.rd_data), 64'd0);
    end
    if (new_cov_o) pulse_cnt++;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic clk_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    cover_i      = '0;
    en_i         = 1'b0;
    clear_i      = 1'b0;
    rd_if.rd_req = 1'b0;
    rd_if.rd_idx = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    exp_q.delete();
    repeat (2) clk_step();
    rst_i = 1'b0;
    clk_step();
    pulse_cnt = 0;
  endtask

  // Issues one read this cycle (leaves rd_req high for back-to-back use).
  task automatic read_word(input widx_t idx, input word_t exp);
    rd_if.rd_req = 1'b1;
    rd_if.rd_idx = idx;
    #1;
    check("rd_gnt", 64'(rd_if.rd_gnt), 64'd1);
    exp_q.push_back(exp);
    clk_step();
  endtask

  task automatic rd_stop();
    rd_if.rd_req = 1'b0;
    rd_if.rd_idx = '0;
  endtask

  initial begin : main
    int unsigned busy_n;
    idle_inputs();
    rst_i = 1'b1;
    clk_step();
    clk_step();
    check("rst_count", 64'(cov_count_o), 64'd0);
    check("rst_new_cov", 64'(new_cov_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_valid", 64'(rd_if.rd_valid), 64'd0);
    rst_i = 1'b0;
    clk_step();

    // Single hit of bit 0: pulse and count arrive after the second edge.
    cover_i[0] = 1'b1;
    en_i       = 1'b1;
    clk_step();
    idle_inputs();
    check("t1_new_cov_early", 64'(new_cov_o), 64'd0);
    check("t1_count_early", 64'(cov_count_o), 64'd0);
    clk_step();
    check("t1_new_cov", 64'(new_cov_o), 64'd1);
    check("t1_count", 64'(cov_count_o), 64'd1);
    clk_step();
    check("t1_new_cov_end", 64'(new_cov_o), 64'd0);
    read_word(widx_t'(0), 32'h0000_0001);
    rd_stop();
    repeat (2) clk_step();

    // Same three bits held for three cycles: counted once, one pulse.
    do_reset();
    cover_i[5]   = 1'b1;
    cover_i[40]  = 1'b1;
    cover_i[336] = 1'b1;
    en_i         = 1'b1;
    repeat (3) clk_step();
    idle_inputs();
    repeat (3) clk_step();
    check("t2_count", 64'(cov_count_o), 64'd3);
    check("t2_pulses", 64'(pulse_cnt), 64'd1);
    read_word(widx_t'(10), 32'h0001_0000);
    read_word(widx_t'(0), 32'h0000_0020);
    read_word(widx_t'(1), 32'h0000_0100);
    rd_stop();
    repeat (2) clk_step();

    // All ones: full count, padding reads zero, out-of-range index reads zero.
    do_reset();
    cover_i = '1;
    en_i    = 1'b1;
    clk_step();
    idle_inputs();
    repeat (2) clk_step();
    check("t3_count", 64'(cov_count_o), 64'd337);
    read_word(widx_t'(10), 32'h0001_FFFF);
    read_word(widx_t'(12), 32'h0000_0000);
    read_word(widx_t'(3), 32'hFFFF_FFFF);
    read_word(widx_t'(0), 32'hFFFF_FFFF);
    rd_stop();
    cover_i = '1;
    en_i    = 1'b1;
    clk_step();
    idle_inputs();
    repeat (2) clk_step();
    check("t3_count_sat", 64'(cov_count_o), 64'd337);

    // Clear with a simultaneous all-ones sample; reads and clear ignored meanwhile.
    pulse_cnt = 0;
    clear_i   = 1'b1;
    en_i      = 1'b1;
    cover_i   = '1;
    clk_step();
    clear_i      = 1'b0;
    rd_if.rd_req = 1'b1;
    check("t4_count_zeroed", 64'(cov_count_o), 64'd0);
    busy_n = 0;
    for (int i = 0; i < 20 && busy_o; i++) begin
      busy_n++;
      clear_i = (i == 3);
      #1;
      check("t4_gnt_in_clear", 64'(rd_if.rd_gnt), 64'd0);
      clk_step();
    end
    idle_inputs();
    check("t4_busy_cycles", 64'(busy_n), 64'd11);
    check("t4_count", 64'(cov_count_o), 64'd0);
    clk_step();
    for (int i = 0; i < int'(NumWords); i++) read_word(widx_t'(i), 32'h0);
    rd_stop();
    repeat (2) clk_step();
    check("t4_count_after", 64'(cov_count_o), 64'd0);
    check("t4_pulses", 64'(pulse_cnt), 64'd0);

    // Reset during the fifth CLEAR cycle aborts the clear.
    cover_i[259] = 1'b1;
    en_i         = 1'b1;
    clk_step();
    idle_inputs();
    repeat (2) clk_step();
    check("t5_count", 64'(cov_count_o), 64'd1);
    clear_i = 1'b1;
    clk_step();
    clear_i = 1'b0;
    repeat (4) clk_step();
    check("t5_busy_mid", 64'(busy_o), 64'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check("t5_rst_busy", 64'(busy_o), 64'd0);
    check("t5_rst_count", 64'(cov_count_o), 64'd0);
    check("t5_rst_new_cov", 64'(new_cov_o), 64'd0);
    check("t5_rst_valid", 64'(rd_if.rd_valid), 64'd0);
    check("t5_rst_data", 64'(rd_if.rd_data), 64'd0);
    clk_step();
    rst_i = 1'b0;
    clk_step();
    check("t5_idle_after", 64'(busy_o), 64'd0);
    read_word(widx_t'(8), 32'h0);
    rd_stop();
    cover_i[259] = 1'b1;
    en_i         = 1'b1;
    clk_step();
    idle_inputs();
    repeat (2) clk_step();
    check("t5_count_fresh", 64'(cov_count_o), 64'd1);

    // Read racing the first hit of bit 33 sees the pre-merge word.
    do_reset();
    cover_i[33] = 1'b1;
    en_i        = 1'b1;
    read_word(widx_t'(1), 32'h0);
    cover_i = '0;
    en_i    = 1'b0;
    read_word(widx_t'(1), 32'h0000_0002);
    rd_stop();
    clk_step();
    pulse_cnt   = 0;
    cover_i[33] = 1'b1;
    en_i        = 1'b1;
    clk_step();
    idle_inputs();
    repeat (2) clk_step();
    check("t6_repeat_count", 64'(cov_count_o), 64'd1);
    check("t6_repeat_pulses", 64'(pulse_cnt), 64'd0);
    cover_i[50] = 1'b1;
    clk_step();
    idle_inputs();
    repeat (2) clk_step();
    check("t6_en_low_count", 64'(cov_count_o), 64'd1);
    read_word(widx_t'(1), 32'h0000_0002);
    rd_stop();
    repeat (2) clk_step();

    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
